// File: rtl/seq_left_shift_of_n_by_var_if.sv
// seq_left_shift_of_n_by_var_if: upstream/downstream valid-ready bundle for the sequential left shifter.
//   up_valid/up_ready/up_data/up_shamt : operand handshake (producer -> shifter)
//   down_valid/down_ready/down_data    : result handshake (shifter -> consumer)
//   modport slave  : the shifter side
//   modport master : the producer/consumer side
interface seq_left_shift_of_n_by_var_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shamt;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;
    modport slave  (input up_valid, up_data, up_shamt, down_ready, output up_ready, down_valid, down_data);
    modport master (output up_valid, up_data, up_shamt, down_ready, input up_ready, down_valid, down_data);
endinterface

// File: rtl/seq_left_shift_of_n_by_var.sv
// seq_left_shift_of_n_by_var: multi-cycle logical left shift, at most STEP bits per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of the up_/down_ valid-ready bundle; down_data = up_data << up_shamt
module seq_left_shift_of_n_by_var #(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int SW   = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    seq_left_shift_of_n_by_var_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SW:0] STEP_W = (SW + 1)'(STEP);
    state_t        state;
    logic [N-1:0]  data;
    logic [SW-1:0] rem;
    logic [SW:0]   amt;
    // compare in SW+1 bits so STEP never wraps against rem
    always_comb amt = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
    assign bus.down_data = data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            data           <= '0;
            rem            <= '0;
            bus.up_ready   <= 1'b0;
            bus.down_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.up_ready <= 1'b1;
                    if (bus.up_valid && bus.up_ready) begin
                        data           <= bus.up_data;
                        rem            <= bus.up_shamt;
                        bus.up_ready   <= 1'b0;
                        bus.down_valid <= bus.up_shamt == '0;
                        state          <= (bus.up_shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data <= data << amt;
                    rem  <= rem - amt[SW-1:0];
                    if (rem == amt[SW-1:0]) begin
                        state          <= DONE;
                        bus.down_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // up_ready rises with the handshake, so the next accept is one cycle later
                    if (bus.down_ready) begin
                        state          <= IDLE;
                        bus.down_valid <= 1'b0;
                        bus.up_ready   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
